// File: rtl/pipe_controller.sv
// Control path for a 5-stage MIPS-style pipeline: decodes in D and
// carries the Execute/Memory/Writeback controls down the pipe.
module pipe_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opD,
    input  logic [5:0] functD,
    input  logic       equalD,
    input  logic       flushE,
    output logic       pcsrcD,
    output logic       branchD,
    output logic       jumpD,
    output logic       regwriteE,
    output logic       memtoregE,
    output logic       alusrcE,
    output logic       regdstE,
    output logic [2:0] alucontrolE,
    output logic       regwriteM,
    output logic       memtoregM,
    output logic       memwriteM,
    output logic       regwriteW,
    output logic       memtoregW
);

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic [2:0] alucontrol;
    } ex_ctrl_t;

    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic [1:0] aluop;
    logic       legal;
    logic [2:0] alucontrol;

    ex_ctrl_t   decoded;
    ex_ctrl_t   ex_q;
    logic [2:0] mem_q;
    logic [1:0] wb_q;

    // Main opcode decode; unknown opcodes become an all-zero bubble.
    always_comb begin
        legal = 1'b1;
        {regwrite, regdst, alusrc, branch,
         memwrite, memtoreg, jump, aluop} = 9'b0;
        case (opD)
            6'b000000: {regwrite, regdst, alusrc, branch, memwrite,
                        memtoreg, jump, aluop} = 9'b1_1_0_0_0_0_0_10;
            6'b100011: {regwrite, regdst, alusrc, branch, memwrite,
                        memtoreg, jump, aluop} = 9'b1_0_1_0_0_1_0_00;
            6'b101011: {regwrite, regdst, alusrc, branch, memwrite,
                        memtoreg, jump, aluop} = 9'b0_0_1_0_1_0_0_00;
            6'b000100: {regwrite, regdst, alusrc, branch, memwrite,
                        memtoreg, jump, aluop} = 9'b0_0_0_1_0_0_0_01;
            6'b001000: {regwrite, regdst, alusrc, branch, memwrite,
                        memtoreg, jump, aluop} = 9'b1_0_1_0_0_0_0_00;
            6'b000010: {regwrite, regdst, alusrc, branch, memwrite,
                        memtoreg, jump, aluop} = 9'b0_0_0_0_0_0_1_00;
            default:   legal = 1'b0;
        endcase
    end

    // ALU operation select from aluop and, for R-type, the funct field.
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01:   alucontrol = 3'b110;
            2'b10: begin
                case (functD)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // An illegal opcode zeroes the whole bundle, alucontrol included,
    // so it looks identical to a flushed bubble downstream.
    always_comb begin
        decoded = '0;
        if (legal) begin
            decoded.regwrite   = regwrite;
            decoded.memtoreg   = memtoreg;
            decoded.memwrite   = memwrite;
            decoded.alusrc     = alusrc;
            decoded.regdst     = regdst;
            decoded.alucontrol = alucontrol;
        end
    end

    assign branchD = branch;
    assign jumpD   = jump;
    assign pcsrcD  = branch & equalD;

    // D->E register; a flush loads a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       ex_q <= '0;
        else if (flushE) ex_q <= '0;
        else             ex_q <= decoded;
    end

    // E->M and M->W registers advance every cycle, unaffected by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= {ex_q.regwrite, ex_q.memtoreg, ex_q.memwrite};
            wb_q  <= mem_q[2:1];
        end
    end

    assign regwriteE   = ex_q.regwrite;
    assign memtoregE   = ex_q.memtoreg;
    assign alusrcE     = ex_q.alusrc;
    assign regdstE     = ex_q.regdst;
    assign alucontrolE = ex_q.alucontrol;

    assign regwriteM   = mem_q[2];
    assign memtoregM   = mem_q[1];
    assign memwriteM   = mem_q[0];

    assign regwriteW   = wb_q[1];
    assign memtoregW   = wb_q[0];

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: decode table, corner sequences and
// randomized traffic checked against a queue-based pipeline model.
module tb_pipe_controller;

    logic       clk;
    logic       reset;
    logic [5:0] opD;
    logic [5:0] functD;
    logic       equalD;
    logic       flushE;
    logic       pcsrcD, branchD, jumpD;
    logic       regwriteE, memtoregE, alusrcE, regdstE;
    logic [2:0] alucontrolE;
    logic       regwriteM, memtoregM, memwriteM;
    logic       regwriteW, memtoregW;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       rw;
        logic       mtr;
        logic       mw;
        logic       as;
        logic       rd;
        logic [2:0] alu;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       eq;
        logic       fl;
        logic [2:0] d;
        logic [6:0] e;
    } vec_t;

    ctl_t pipe_q[$];

    pipe_controller dut (
        .clk(clk), .reset(reset), .opD(opD), .functD(functD),
        .equalD(equalD), .flushE(flushE),
        .pcsrcD(pcsrcD), .branchD(branchD), .jumpD(jumpD),
        .regwriteE(regwriteE), .memtoregE(memtoregE),
        .alusrcE(alusrcE), .regdstE(regdstE),
        .alucontrolE(alucontrolE),
        .regwriteM(regwriteM), .memtoregM(memtoregM),
        .memwriteM(memwriteM),
        .regwriteW(regwriteW), .memtoregW(memtoregW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controls an instruction should carry, straight from the ISA table.
    function automatic ctl_t ref_ctl(input logic [5:0] op,
                                     input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (op)
            6'd0: begin
                c.rw = 1; c.rd = 1;
                case (fn)
                    6'b100010: c.alu = 3'b110;
                    6'b100100: c.alu = 3'b000;
                    6'b100101: c.alu = 3'b001;
                    6'b101010: c.alu = 3'b111;
                    default:   c.alu = 3'b010;
                endcase
            end
            6'd35: begin c.rw = 1; c.as = 1; c.mtr = 1; c.alu = 3'b010; end
            6'd43: begin c.as = 1; c.mw = 1; c.alu = 3'b010; end
            6'd4:  c.alu = 3'b110;
            6'd8:  begin c.rw = 1; c.as = 1; c.alu = 3'b010; end
            6'd2:  c.alu = 3'b010;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] ref_d(input logic [5:0] op,
                                         input logic eq);
        logic br, jp;
        br = (op == 6'd4);
        jp = (op == 6'd2);
        return {br & eq, br, jp};
    endfunction

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_pipe();
        ctl_t e, m, w;
        e = (pipe_q.size() > 0) ? pipe_q[0] : '0;
        m = (pipe_q.size() > 1) ? pipe_q[1] : '0;
        w = (pipe_q.size() > 2) ? pipe_q[2] : '0;
        check("e_stage",
              {1'b0, regwriteE, memtoregE, alusrcE, regdstE, alucontrolE},
              {1'b0, e.rw, e.mtr, e.as, e.rd, e.alu});
        check("m_stage", {5'b0, regwriteM, memtoregM, memwriteM},
              {5'b0, m.rw, m.mtr, m.mw});
        check("w_stage", {6'b0, regwriteW, memtoregW},
              {6'b0, w.rw, w.mtr});
    endtask

    // One cycle: drive D, check D outputs, clock, update model, check pipe.
    task automatic step(input logic [5:0] op, input logic [5:0] fn,
                        input logic eq, input logic fl);
        opD = op; functD = fn; equalD = eq; flushE = fl;
        #1;
        check("d_outputs", {5'b0, pcsrcD, branchD, jumpD},
              {5'b0, ref_d(op, eq)});
        @(posedge clk);
        if (reset) begin
            pipe_q.delete();
        end else begin
            pipe_q.push_front(fl ? ctl_t'('0) : ref_ctl(op, fn));
            if (pipe_q.size() > 3) void'(pipe_q.pop_back());
        end
        #1;
        check_pipe();
    endtask

    vec_t tbl[14];
    logic [5:0] ops[7];
    logic [5:0] fns[6];

    initial begin
        tbl = '{
            '{6'd35, 6'd0,  1'b0, 1'b0, 3'b000, 7'b1110_010},
            '{6'd0,  6'h2a, 1'b0, 1'b0, 3'b000, 7'b1001_111},
            '{6'd0,  6'h25, 1'b0, 1'b0, 3'b000, 7'b1001_001},
            '{6'd0,  6'h24, 1'b0, 1'b0, 3'b000, 7'b1001_000},
            '{6'd0,  6'h20, 1'b0, 1'b0, 3'b000, 7'b1001_010},
            '{6'd0,  6'h22, 1'b0, 1'b0, 3'b000, 7'b1001_110},
            '{6'd0,  6'h3f, 1'b0, 1'b0, 3'b000, 7'b1001_010},
            '{6'd4,  6'd0,  1'b1, 1'b0, 3'b110, 7'b0000_110},
            '{6'd4,  6'd0,  1'b0, 1'b0, 3'b010, 7'b0000_110},
            '{6'd43, 6'd0,  1'b0, 1'b1, 3'b000, 7'b0000_000},
            '{6'd8,  6'd0,  1'b0, 1'b0, 3'b000, 7'b1010_010},
            '{6'd43, 6'd0,  1'b0, 1'b0, 3'b000, 7'b0010_010},
            '{6'd2,  6'd0,  1'b1, 1'b0, 3'b001, 7'b0000_010},
            '{6'd63, 6'd0,  1'b1, 1'b0, 3'b000, 7'b0000_000}
        };
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd63};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};

        reset = 1'b1; opD = '0; functD = '0; equalD = 0; flushE = 0;
        #1;
        check_pipe();
        opD = 6'd4; equalD = 1'b1;
        #1;
        check("d_in_reset", {5'b0, pcsrcD, branchD, jumpD}, 8'h06);
        step(6'd35, 6'd0, 1'b0, 1'b0);
        step(6'd35, 6'd0, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].op, tbl[i].fn, tbl[i].eq, tbl[i].fl);
            check($sformatf("tbl%0d_d", i),
                  {5'b0, pcsrcD, branchD, jumpD}, {5'b0, tbl[i].d});
            check($sformatf("tbl%0d_e", i),
                  {1'b0, regwriteE, memtoregE, alusrcE, regdstE,
                   alucontrolE}, {1'b0, tbl[i].e});
        end

        step(6'd35, 6'd0, 1'b0, 1'b0);
        step(6'd63, 6'd0, 1'b0, 1'b0);
        check("lw_in_m", {6'b0, regwriteM, memtoregM}, 8'h03);
        step(6'd63, 6'd0, 1'b0, 1'b0);
        check("lw_in_w", {6'b0, regwriteW, memtoregW}, 8'h03);

        step(6'd35, 6'd0, 1'b0, 1'b0);
        step(6'd35, 6'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        pipe_q.delete();
        check("async_rst_m", {6'b0, regwriteM, memtoregM}, 8'h00);
        check("async_rst_w", {6'b0, regwriteW, memtoregW}, 8'h00);
        check_pipe();
        step(6'd35, 6'd0, 1'b0, 1'b1);
        reset = 1'b0;
        step(6'd63, 6'd0, 1'b0, 1'b0);
        step(6'd63, 6'd0, 1'b0, 1'b0);
        step(6'd63, 6'd0, 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom)
                                             : ops[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 5) == 5) ? 6'($urandom)
                                             : fns[$urandom_range(0, 5)];
            reset = ($urandom_range(0, 31) == 0);
            step(op, fn, 1'($urandom), $urandom_range(0, 3) == 0);
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 opD  input  6  opcode of instruction in Decode.
REQ-005 functD  input  6  funct field of instruction in Decode.
REQ-006 equalD  input  1  register-compare result from Decode.
REQ-007 flushE  input  1  bubble request from hazard unit; clears the Decode-to-Execute control register.
REQ-008 pcsrcD  output  1  take branch.
REQ-009 branchD  output  1  Decode instruction is beq.
REQ-010 jumpD  output  1  Decode instruction is j.
REQ-011 regwriteE, memtoregE, alusrcE, regdstE  output  1 each  Execute-stage controls.
REQ-012 alucontrolE  output  3  Execute-stage ALU operation.
REQ-013 regwriteM, memtoregM, memwriteM  output  1 each  Memory-stage controls.
REQ-014 regwriteW, memtoregW  output  1 each  Writeback-stage controls.

Function
REQ-015 Main decode of opD SHALL be combinational, giving {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop[1:0]}:
 - 000000 R-type: regwrite=1, regdst=1, aluop=10.
 - 100011 lw: regwrite=1, alusrc=1, memtoreg=1, aluop=00.
 - 101011 sw: alusrc=1, memwrite=1, aluop=00.
 - 000100 beq: branch=1, aluop=01.
 - 001000 addi: regwrite=1, alusrc=1, aluop=00.
 - 000010 j: jump=1.
 - any other opcode: all controls 0 (bubble); no X outputs.
REQ-016 ALU decode SHALL be combinational: aluop 00 -> 010; aluop 01 -> 110; aluop 10 by functD: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010 with regwrite unchanged. aluop 11 does not occur and SHALL decode as 010.
REQ-017 branchD and jumpD SHALL be driven combinationally from the current opD, with zero latency.
REQ-018 pcsrcD SHALL equal branchD AND equalD, combinationally.
REQ-019 The D->E register SHALL capture {regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol} every clock edge; no enable.
REQ-020 When flushE=1 at a clock edge, the D->E register SHALL load all zeros instead of the decoded values, giving an Execute bubble.
REQ-021 The E->M register SHALL capture {regwriteE, memtoregE, memwriteE} every edge and SHALL ignore flushE.
REQ-022 The M->W register SHALL capture {regwriteM, memtoregM} every edge.
REQ-023 Latency: controls decoded in cycle n appear at E outputs in n+1, M in n+2 and W in n+3.
REQ-024 A flushed bubble SHALL propagate as zeros through M and W in the following cycles.
REQ-025 Each instruction's controls SHALL advance exactly one stage per cycle and SHALL never be duplicated or dropped, except by flushE.

Reset
REQ-026 While reset=1, every E/M/W output SHALL be 0 asynchronously, independent of clk.
REQ-027 Reset SHALL have priority over flushE.
REQ-028 The first edge after reset deasserts SHALL load decoded opD normally.
REQ-029 Combinational D outputs SHALL follow opD and equalD even during reset.
REQ-030 Reset mid-pipeline SHALL discard all in-flight controls; none reappear afterwards.

Verification
REQ-031 lw (100011) in D, flushE=0 -> next cycle regwriteE=1, memtoregE=1, alusrcE=1, alucontrolE=010; then regwriteM=1, memtoregM=1; then regwriteW=1, memtoregW=1.
REQ-032 R-type with funct 101010 -> alucontrolE=111, regdstE=1, regwriteE=1; funct 100101 -> alucontrolE=001.
REQ-033 beq with equalD=1 -> pcsrcD=1, branchD=1 the same cycle; with equalD=0 -> pcsrcD=0. Next cycle alucontrolE=110 and regwriteE=0.
REQ-034 sw in D with flushE=1 -> all E outputs 0 next cycle and memwriteM=0 the cycle after. Back-to-back instructions without flush are unaffected.
REQ-035 Illegal opcode 111111 -> all D outputs 0 and all downstream stages 0.
REQ-036 Async reset asserted between edges while lw is in M -> regwriteM, memtoregM, memtoregW and regwriteW drop to 0 before the next edge. Reset asserted together with flushE -> outputs 0.
